uart_rx_buf: RTL and testbench

Receive-side byte FIFO between the `buart` receiver and the lab DUT, mirroring `uartTxBuf` on the transmit path. Single-cycle `bu_rx_data_rdy` strobes are captured so bytes are not lost while the consumer is busy. The consumer reads through a first-word-fall-through pop handshake. Overflow is detected, counted and flagged.

---
 rtl/uart_rx_buf.sv | 115 +++++++++++
 tb/tb_uart_rx_buf.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_buf                                                   |
// | Purpose  : Receive byte FIFO (first-word-fall-through) between the UART  |
// |            receiver and its consumer, with overflow flag and drop count. |
// | Option   : UART_RX_BUF_ESC_FLUSH_EN - a pushed ESC (8'h1B) flushes FIFO. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_rx_buf #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            bu_rx_data,
  input  logic                  bu_rx_data_rdy,
  input  logic                  rb_rd,
  input  logic                  rb_ovf_clr,
  output logic [7:0]            rb_data,
  output logic                  rb_data_rdy,
  output logic [DEPTH_LOG2:0]   rb_count,
  output logic                  rb_full,
  output logic                  rb_overflow,
  output logic [7:0]            rb_drop_cnt
);

  localparam int                    c_depth      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   c_full_count = (DEPTH_LOG2 + 1)'(c_depth);
  localparam logic [DEPTH_LOG2:0]   c_cnt_one    = 1;
  localparam logic [DEPTH_LOG2-1:0] c_ptr_one    = 1;

  logic [7:0]            r_mem [0:c_depth-1];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic [7:0]            r_drop_cnt;

  logic w_empty;
  logic w_full;
  logic w_esc;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_full_count);

`ifdef UART_RX_BUF_ESC_FLUSH_EN
  assign w_esc = bu_rx_data_rdy && (bu_rx_data == 8'h1B);
`else
  assign w_esc = 1'b0;
`endif

  // A flush overrides any coincident pop; a pop frees the slot a full push needs.
  assign w_pop  = rb_rd && !w_empty && !w_esc;
  assign w_push = bu_rx_data_rdy && !w_esc && (!w_full || w_pop);
  assign w_drop = bu_rx_data_rdy && !w_esc && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= bu_rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_esc) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

  // A drop in the same cycle as a clear wins and counts as the first new drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'h00;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (rb_ovf_clr) begin
        r_drop_cnt <= 8'h01;
      end else if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'h01;
      end
    end else if (rb_ovf_clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'h00;
    end
  end

  assign rb_data     = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign rb_data_rdy = !w_empty;
  assign rb_count    = r_count;
  assign rb_full     = w_full;
  assign rb_overflow = r_overflow;
  assign rb_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx_buf                                                |
// | Purpose  : Self-checking bench for uart_rx_buf against a queue model.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_rx_buf;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [7:0]          bu_rx_data = 8'h00;
  logic                bu_rx_data_rdy = 1'b0;
  logic                rb_rd = 1'b0;
  logic                rb_ovf_clr = 1'b0;
  logic [7:0]          rb_data;
  logic                rb_data_rdy;
  logic [DEPTH_LOG2:0] rb_count;
  logic                rb_full;
  logic                rb_overflow;
  logic [7:0]          rb_drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_buf #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk            (clk),
    .rst            (rst),
    .bu_rx_data     (bu_rx_data),
    .bu_rx_data_rdy (bu_rx_data_rdy),
    .rb_rd          (rb_rd),
    .rb_ovf_clr     (rb_ovf_clr),
    .rb_data        (rb_data),
    .rb_data_rdy    (rb_data_rdy),
    .rb_count       (rb_count),
    .rb_full        (rb_full),
    .rb_overflow    (rb_overflow),
    .rb_drop_cnt    (rb_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: the FIFO as a plain queue plus an overflow flag and drop tally.
  logic [7:0] q[$];
  bit         m_ovf  = 1'b0;
  int         m_drop = 0;
  bit         m_live = 1'b0;

  always @(posedge clk) begin
    bit esc, popped, room;
    if (rst) begin
      q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
      m_live = 1'b1;
    end else begin
      esc = 1'b0;
`ifdef UART_RX_BUF_ESC_FLUSH_EN
      esc = bu_rx_data_rdy && (bu_rx_data == 8'h1B);
`endif
      if (rb_ovf_clr) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
      if (esc) begin
        q.delete();
      end else begin
        popped = rb_rd && (q.size() > 0);
        room   = (q.size() < DEPTH) || popped;
        if (popped) void'(q.pop_front());
        if (bu_rx_data_rdy && room) q.push_back(bu_rx_data);
        if (bu_rx_data_rdy && !room) begin
          m_ovf  = 1'b1;
          m_drop = (m_drop == 255) ? 255 : m_drop + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("data",     int'(rb_data),     (q.size() > 0) ? int'(q[0]) : 0);
      chk("data_rdy", int'(rb_data_rdy), int'(q.size() > 0));
      chk("count",    int'(rb_count),    q.size());
      chk("full",     int'(rb_full),     int'(q.size() == DEPTH));
      chk("overflow", int'(rb_overflow), int'(m_ovf));
      chk("drop_cnt", int'(rb_drop_cnt), m_drop);
    end
  end

  // One clock: drive inputs, pass the edge, return 1 time unit after it.
  task automatic cyc(input bit p, input logic [7:0] d, input bit r, input bit c);
    bu_rx_data_rdy = p;
    bu_rx_data     = d;
    rb_rd          = r;
    rb_ovf_clr     = c;
    @(posedge clk);
    #1;
    bu_rx_data_rdy = 1'b0;
    rb_rd          = 1'b0;
    rb_ovf_clr     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 8'h00, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_data",  int'(rb_data), 0);
    chk("rst_rdy",   int'(rb_data_rdy), 0);
    chk("rst_count", int'(rb_count), 0);
    chk("rst_full",  int'(rb_full), 0);
    chk("rst_ovf",   int'(rb_overflow), 0);
    chk("rst_drop",  int'(rb_drop_cnt), 0);

    cyc(1, 8'h41, 0, 0);
    chk("one_data",  int'(rb_data), 8'h41);
    chk("one_rdy",   int'(rb_data_rdy), 1);
    chk("one_count", int'(rb_count), 1);
    cyc(0, 8'h00, 1, 0);
    chk("pop_rdy",   int'(rb_data_rdy), 0);
    chk("pop_data",  int'(rb_data), 0);
    chk("pop_count", int'(rb_count), 0);

    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
    chk("fill_full",  int'(rb_full), 1);
    chk("fill_count", int'(rb_count), 16);
    cyc(1, 8'h10, 0, 0);
    chk("drop1_ovf",  int'(rb_overflow), 1);
    chk("drop1_cnt",  int'(rb_drop_cnt), 1);
    chk("drop1_count", int'(rb_count), 16);
    for (int i = 0; i < 16; i++) begin
      chk("order_data", int'(rb_data), i);
      cyc(0, 8'h00, 1, 0);
    end
    chk("drained_rdy", int'(rb_data_rdy), 0);
    cyc(0, 8'h00, 0, 1);
    chk("clr_ovf", int'(rb_overflow), 0);

    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0, 0);
    cyc(1, 8'h55, 1, 0);
    chk("fullpp_count", int'(rb_count), 16);
    chk("fullpp_ovf",   int'(rb_overflow), 0);
    chk("fullpp_head",  int'(rb_data), 8'h21);
    for (int i = 0; i < 15; i++) cyc(0, 8'h00, 1, 0);
    chk("fullpp_last",  int'(rb_data), 8'h55);
    cyc(0, 8'h00, 1, 0);
    cyc(1, 8'h66, 1, 0);
    chk("emptypp_count", int'(rb_count), 1);
    chk("emptypp_head",  int'(rb_data), 8'h66);
    cyc(0, 8'h00, 1, 0);

    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h30 + i), 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 8'(8'h80 + i), 0, 0);
    chk("drop20_cnt", int'(rb_drop_cnt), 20);
    cyc(1, 8'hA5, 0, 1);
    chk("clrdrop_ovf", int'(rb_overflow), 1);
    chk("clrdrop_cnt", int'(rb_drop_cnt), 1);

    do_reset();
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h02, 0, 0);
    cyc(1, 8'h03, 0, 0);
    cyc(1, 8'h1B, 0, 0);
`ifdef UART_RX_BUF_ESC_FLUSH_EN
    chk("esc_count", int'(rb_count), 0);
`else
    chk("esc_count", int'(rb_count), 4);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0);
    chk("esc_last", int'(rb_data), 8'h1B);
    cyc(0, 8'h00, 1, 0);
`endif

    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h60 + i), 0, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 0);
    rst = 1'b1;
    cyc(1, 8'h99, 1, 0);
    rst = 1'b0;
    chk("midrst_count", int'(rb_count), 0);
    chk("midrst_rdy",   int'(rb_data_rdy), 0);
    chk("midrst_data",  int'(rb_data), 0);
    chk("midrst_ovf",   int'(rb_overflow), 0);
    cyc(1, 8'h7E, 0, 0);
    chk("after_head",  int'(rb_data), 8'h7E);
    chk("after_count", int'(rb_count), 1);

    // Random traffic; push/pop bias changes per segment to visit empty and full.
    for (int seg = 0; seg < 8; seg++) begin
      int pp, rp;
      pp = (seg % 2 == 0) ? 80 : 30;
      rp = (seg % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 400; i++) begin
        logic [7:0] d;
        d = ($urandom_range(0, 15) == 0) ? 8'h1B : 8'($urandom);
        rst = ($urandom_range(0, 299) == 0);
        cyc($urandom_range(0, 99) < pp, d, $urandom_range(0, 99) < rp,
            $urandom_range(0, 49) == 0);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
